// File: rtl/asp_rxe.sv
// asp_rxe: network receive endpoint. Classifies tagged words against an
// expected sequence tag, ACKs them and queues data+parity in a 2-deep FIFO.
// Ports: clk, reset (sync, active-high); network_data_ready_in,
// network_data_tag_in {data,tag}, network_ACK_out; host_data_accept_in,
// host_data_ready_out, host_data_parity_out {data,parity};
// tag_error_out, overflow_out (one-cycle pulses).
module asp_rxe #(
  parameter int data_size = 32,
  parameter int tag_size  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          network_data_ready_in,
  input  logic [data_size+tag_size-1:0] network_data_tag_in,
  input  logic                          host_data_accept_in,
  output logic                          network_ACK_out,
  output logic                          host_data_ready_out,
  output logic [data_size:0]            host_data_parity_out,
  output logic                          tag_error_out,
  output logic                          overflow_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT_LOW
  } state_t;

  state_t              state;
  logic [tag_size-1:0] exp_tag;
  logic                ack_q;

  logic [data_size:0]  mem [2];
  logic                rd_ptr;
  logic                wr_ptr;
  logic [1:0]          count;

  logic [data_size-1:0] data;
  logic [tag_size-1:0]  tag;
  logic [tag_size-1:0]  dup_tag;
  logic                 is_new;
  logic                 is_dup;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  assign data    = network_data_tag_in[data_size+tag_size-1:tag_size];
  assign tag     = network_data_tag_in[tag_size-1:0];
  assign dup_tag = exp_tag - tag_size'(1);
  assign is_new  = (tag == exp_tag);
  assign is_dup  = (tag == dup_tag);

  // full is judged on start-of-cycle occupancy; a same-cycle pop
  // does not make room for the push
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign push  = (state == IDLE) && network_data_ready_in
               && is_new && !full;
  assign pop   = host_data_accept_in && !empty;

  // reset also kills an ACK already on the wire this cycle
  assign network_ACK_out      = ack_q & ~reset;
  assign host_data_ready_out  = !empty;
  assign host_data_parity_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      exp_tag       <= '0;
      ack_q         <= 1'b0;
      tag_error_out <= 1'b0;
      overflow_out  <= 1'b0;
    end else begin
      ack_q         <= 1'b0;
      tag_error_out <= 1'b0;
      overflow_out  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (network_data_ready_in) begin
            unique case (1'b1)
              is_new && !full: begin
                exp_tag <= exp_tag + tag_size'(1);
                ack_q   <= 1'b1;
                state   <= ACK;
              end
              is_new && full: begin
                overflow_out <= 1'b1;
                state        <= WAIT_LOW;
              end
              is_dup: begin
                ack_q <= 1'b1;
                state <= ACK;
              end
              default: begin
                tag_error_out <= 1'b1;
                state         <= WAIT_LOW;
              end
            endcase
          end
        end
        ACK: state <= WAIT_LOW;
        WAIT_LOW: begin
          if (!network_data_ready_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {data, ^data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_asp_rxe.sv
// tb_asp_rxe: randomized + directed bench for asp_rxe with a
// queue-based reference model of the receiver.
module tb_asp_rxe;

  logic        clk = 1'b0;
  logic        reset;
  logic        rdy;
  logic [39:0] word;
  logic        acc;
  logic        ack;
  logic        hrdy;
  logic [32:0] hpar;
  logic        terr;
  logic        ovf;

  asp_rxe dut (
    .clk                  (clk),
    .reset                (reset),
    .network_data_ready_in(rdy),
    .network_data_tag_in  (word),
    .host_data_accept_in  (acc),
    .network_ACK_out      (ack),
    .host_data_ready_out  (hrdy),
    .host_data_parity_out (hpar),
    .tag_error_out        (terr),
    .overflow_out         (ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 0;

  logic [31:0] q[$];
  int m_exp;
  bit m_ack, m_err, m_ovf;
  bit blind, need_low;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [32:0] par(input logic [31:0] d);
    return {d, ^d};
  endfunction

  // What the receiver must do on the coming edge, from the rules.
  task automatic model_step();
    bit full;
    logic [31:0] d;
    int t;
    if (reset) begin
      q.delete();
      m_exp = 0;
      m_ack = 0; m_err = 0; m_ovf = 0;
      blind = 0; need_low = 0;
      return;
    end
    full = (q.size() == 2);
    d = word[39:8];
    t = int'(word[7:0]);
    m_ack = 0; m_err = 0; m_ovf = 0;
    if (acc && q.size() > 0) void'(q.pop_front());
    if (blind) begin
      blind = 0;
      need_low = 1;
    end else if (need_low) begin
      if (!rdy) need_low = 0;
    end else if (rdy) begin
      if (t == m_exp) begin
        if (full) begin
          m_ovf = 1;
          need_low = 1;
        end else begin
          q.push_back(d);
          m_exp = (m_exp + 1) % 256;
          m_ack = 1;
          blind = 1;
        end
      end else if (t == (m_exp + 255) % 256) begin
        m_ack = 1;
        blind = 1;
      end else begin
        m_err = 1;
        need_low = 1;
      end
    end
  endtask

  task automatic compare();
    if (!cmp_en) return;
    chk("ack", 64'(ack), 64'(m_ack && !reset));
    chk("tag_err", 64'(terr), 64'(m_err));
    chk("overflow", 64'(ovf), 64'(m_ovf));
    chk("ready", 64'(hrdy), 64'(q.size() != 0));
    if (q.size() != 0) chk("head", 64'(hpar), 64'(par(q[0])));
  endtask

  task automatic cycle();
    @(negedge clk);
    compare();
    model_step();
    cmp_en = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int t, input logic [31:0] d);
    rdy = 1'b1;
    word = {d, 8'(t)};
    cycle();
  endtask

  task automatic release_tx();
    rdy = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic pop1();
    acc = 1'b1;
    cycle();
    acc = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rdy = 1'b0;
    acc = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    bit tx_on;
    int r;
    int tg;
    reset = 1'b1;
    rdy = 1'b0;
    acc = 1'b0;
    word = '0;
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_ready", 64'(hrdy), 64'd0);
    chk("rst_data", 64'(hpar), 64'd0);
    chk("rst_err", 64'(terr), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);

    // first word: ACK and data at N+1
    send(0, 32'hA5A5A5A5);
    chk("r33_ack", 64'(ack), 64'd1);
    chk("r33_ready", 64'(hrdy), 64'd1);
    chk("r33_data", 64'(hpar), 64'h14B4B4B4A);
    release_tx();
    pop1();
    chk("r33_empty", 64'(hrdy), 64'd0);
    send(1, 32'h2);
    chk("r33_tag1_ack", 64'(ack), 64'd1);
    chk("r33_tag1_push", 64'(hpar), 64'h5);
    release_tx();
    pop1();

    // duplicate tags re-ACK without pushing
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(0, 32'h1);
      chk("r34_ack", 64'(ack), 64'd1);
      release_tx();
    end
    chk("r34_head", 64'(hpar), 64'h3);
    pop1();
    chk("r34_one_entry", 64'(hrdy), 64'd0);

    // overflow then retry after a pop
    do_reset();
    send(0, 32'h10);
    release_tx();
    send(1, 32'h20);
    release_tx();
    send(2, 32'h30);
    chk("r35_noack", 64'(ack), 64'd0);
    chk("r35_ovf", 64'(ovf), 64'd1);
    release_tx();
    chk("r35_head0", 64'(hpar), 64'h21);
    pop1();
    chk("r35_head1", 64'(hpar), 64'h41);
    send(2, 32'h30);
    chk("r35_retry_ack", 64'(ack), 64'd1);
    release_tx();
    pop1();
    chk("r35_head2", 64'(hpar), 64'h60);
    pop1();
    chk("r35_empty", 64'(hrdy), 64'd0);

    // bad tag, then 255 is a duplicate right after reset
    do_reset();
    send(5, 32'hDEAD);
    chk("r36_err", 64'(terr), 64'd1);
    chk("r36_noack", 64'(ack), 64'd0);
    chk("r36_empty", 64'(hrdy), 64'd0);
    release_tx();
    send(255, 32'hBEEF);
    chk("r36_dup_ack", 64'(ack), 64'd1);
    chk("r36_dup_nopush", 64'(hrdy), 64'd0);
    release_tx();

    // ready held high: one ACK, one push
    do_reset();
    rdy = 1'b1;
    word = {32'h77, 8'd0};
    acks = 0;
    repeat (5) begin
      cycle();
      acks += int'(ack);
    end
    rdy = 1'b0;
    cycle();
    acks += int'(ack);
    cycle();
    chk("r37_acks", 64'(acks), 64'd1);
    chk("r37_head", 64'(hpar), 64'hEE);
    pop1();
    chk("r37_one_push", 64'(hrdy), 64'd0);

    // walk the tag to 255 and wrap to 0
    acc = 1'b1;
    for (int t = 1; t < 255; t++) begin
      send(t, 32'(t));
      release_tx();
    end
    acc = 1'b0;
    cycle();
    send(255, 32'hAB);
    chk("r37_255_ack", 64'(ack), 64'd1);
    release_tx();
    send(0, 32'hCD);
    chk("r37_wrap_ack", 64'(ack), 64'd1);
    release_tx();
    chk("r37_wrap_head0", 64'(hpar), 64'h157);
    pop1();
    chk("r37_wrap_head1", 64'(hpar), 64'h19B);
    pop1();
    chk("r37_wrap_empty", 64'(hrdy), 64'd0);

    // reset during the ACK cycle
    do_reset();
    send(0, 32'h55);
    reset = 1'b1;
    rdy = 1'b0;
    #1;
    chk("r38_ack_cancel", 64'(ack), 64'd0);
    cycle();
    chk("r38_empty", 64'(hrdy), 64'd0);
    reset = 1'b0;
    send(0, 32'h66);
    chk("r38_ack", 64'(ack), 64'd1);
    chk("r38_head", 64'(hpar), 64'hCC);
    release_tx();
    pop1();

    // random traffic against the model
    tx_on = 0;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      acc = ($urandom_range(0, 2) == 0);
      if (tx_on) begin
        if (m_ack || $urandom_range(0, 15) == 0) begin
          rdy = 1'b0;
          tx_on = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 6) tg = m_exp;
        else if (r < 8) tg = (m_exp + 255) % 256;
        else tg = $urandom_range(0, 255);
        word = {32'($urandom), 8'(tg)};
        rdy = 1'b1;
        tx_on = 1;
      end
      cycle();
    end
    reset = 1'b0;
    rdy = 1'b0;
    acc = 1'b0;
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/asp_rxe.md
ASP_RXE -- requirements
Module: asp_rxe

Interface
REQ-001 Parameter data_size, default 32: width of the host data word.
REQ-002 Parameter tag_size, default 8: width of the network sequence tag.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 network_data_ready_in  input  1  transmitter asserts while a valid word is presented; held until network_ACK_out is seen.
REQ-006 network_data_tag_in  input  data_size+tag_size  packed word: data in bits [data_size+tag_size-1:tag_size], tag in bits [tag_size-1:0].
REQ-007 host_data_accept_in  input  1  host consumes the head word in any cycle where host_data_ready_out=1.
REQ-008 network_ACK_out  output  1  one-cycle acknowledge pulse to the transmitter.
REQ-009 host_data_ready_out  output  1  FIFO non-empty; host_data_parity_out is valid.
REQ-010 host_data_parity_out  output  data_size+1  {data, even-parity bit}; parity bit in the LSB.
REQ-011 tag_error_out  output  1  one-cycle pulse on an out-of-sequence tag.
REQ-012 overflow_out  output  1  one-cycle pulse when an in-sequence word is dropped because the FIFO is full.

Function
REQ-013 The FSM SHALL have states IDLE, ACK and WAIT_LOW.
REQ-014 IDLE: when network_data_ready_in=1, the word SHALL be classified, the FSM SHALL go to ACK if acknowledging, otherwise to WAIT_LOW.
REQ-015 ACK: network_ACK_out SHALL be 1 for exactly this one cycle, and the FSM SHALL go to WAIT_LOW.
REQ-016 WAIT_LOW: network_data_ready_in SHALL be ignored while high; the FSM SHALL return to IDLE on the first cycle it is sampled 0.
REQ-017 expected_tag (tag_size bits) SHALL reset to 0.
REQ-018 Classification: tag==expected_tag -> NEW; tag==expected_tag-1 (mod 2^tag_size) -> DUP; otherwise ERR.
REQ-019 NEW with the FIFO not full: push {data, ^data}, increment expected_tag modulo 2^tag_size, then ACK.
REQ-020 NEW with the FIFO full: no push, no expected_tag change, pulse overflow_out the next cycle, no ACK (go to WAIT_LOW).
REQ-021 DUP: no push, ACK (this re-acknowledges a lost ACK).
REQ-022 ERR: no push, pulse tag_error_out the next cycle, no ACK.
REQ-023 Immediately after reset, expected_tag-1 equals 2^tag_size-1, so tag 255 SHALL classify as DUP.
REQ-024 The FIFO SHALL have depth 2 and be first-in first-out.
REQ-025 "Full" SHALL be evaluated on the occupancy at the start of the cycle; a same-cycle host pop does not free space for a push.
REQ-026 A simultaneous push and pop on a non-empty FIFO SHALL leave the occupancy unchanged and preserve order.
REQ-027 A pop on an empty FIFO SHALL be ignored.
REQ-028 Latency: a word sampled in IDLE at cycle N SHALL appear on host_data_parity_out with host_data_ready_out=1 at cycle N+1 if the FIFO was empty, and network_ACK_out SHALL be 1 at cycle N+1.
REQ-029 host_data_parity_out SHALL always show the head entry and SHALL be held stable until popped.
REQ-030 The parity bit SHALL be the XOR of all data bits, giving even parity over all data_size+1 bits.

Reset
REQ-031 On reset: FSM=IDLE, expected_tag=0, FIFO empty, and all outputs 0 (host_data_parity_out=0).
REQ-032 Reset SHALL override every other input in the same cycle, including mid-ACK and mid-WAIT_LOW; a pending ACK SHALL be cancelled.

Verification
REQ-033 Reset, then present data 0xA5A5A5A5 with tag 0 -> ACK pulse at N+1, host_data_parity_out=0x14B4B4B4A (parity 0), and expected_tag becomes 1.
REQ-034 Present data 0x00000001 with tag 0 three times with no host pop -> first ACK; second (DUP) ACK with no push; FIFO holds 1 entry with parity bit 1.
REQ-035 With 2 words pushed and no pop, present tag 2 -> overflow_out pulse, no ACK, expected_tag stays 2; pop one, re-present tag 2 -> ACK and push.
REQ-036 After reset, present tag 5 -> tag_error_out pulse, no ACK, FIFO empty; tag 255 -> ACK with no push.
REQ-037 Hold network_data_ready_in high for 5 cycles -> exactly one ACK and one push; a tag sequence running through 255 then 0 -> expected_tag wraps and both words are accepted.
REQ-038 Assert reset in the ACK cycle -> no ACK pulse, FIFO empty, and the next tag 0 is accepted.
